tile_port_a_sequencer: RTL and testbench
========================================

// Module: tile_port_a_sequencer
// PURPOSE
//  Owns write/read port A of the display tile BRAM (the ASCII code per 8x16 tile).
//  Sequences four operations on it: single-character write at the text cursor,
//  full-screen clear, one-row scroll-up, and automatic scroll when the cursor runs
//  off the last tile. Port B stays dedicated to the pixel renderer.
//  Sits between the button/edge-detect logic and the tile BRAM in the text display top.
// PARAMETERS
//  COLS        160    tiles per row (1280/8)
//  ROWS        45     tile rows (720/16)
//  COL_BITS    8      column field width of the tile address
//  ROW_BITS    6      row field width of the tile address
//  ADDR_WIDTH  14     tile BRAM address width (ROW_BITS+COL_BITS)
//  FILL_CHAR   8'h20  code written by clear and by scroll fill (space)
// PORTS
//  clk_75mhz   in   1           system/pixel clock
//  rst_sync    in   1           reset: asynchronous, active-high; clock is clk_75mhz
//  wr_req      in   1           1-cycle pulse: write wr_char at cursor, advance cursor
//  wr_char     in   8           ASCII code for wr_req, sampled on the wr_req cycle
//  clear_req   in   1           1-cycle pulse: fill all tiles with FILL_CHAR, home cursor
//  scroll_req  in   1           1-cycle pulse: shift rows up by one, blank last row
//  bram_dout   in   8           port A read data, valid 1 cycle after bram_addr
//  bram_we     out  1           port A write enable
//  bram_addr   out  ADDR_WIDTH  port A address = {row, col}
//  bram_din    out  8           port A write data
//  cursor_col  out  COL_BITS    cursor column, 0..COLS-1
//  cursor_row  out  ROW_BITS    cursor row, 0..ROWS-1
//  busy        out  1           high in every non-IDLE state
//  done        out  1           1-cycle pulse on return to IDLE after any operation
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, cursor (0,0). Async assert aborts any operation
//   at once; BRAM contents after a mid-operation reset are undefined.
//  Port A outputs decode directly from state/counter registers (no extra stage).
//  Columns COLS..2^COL_BITS-1 are never addressed.
//  States: IDLE, WRITE, CLEAR, SCR_RD, SCR_WR, SCR_FILL.
//  IDLE: requests are accepted only here; priority clear > scroll > write.
//   Losing and in-flight (busy) requests are dropped, not queued.
//  WRITE (1 cycle): we=1, addr={cursor}, din=latched wr_char. Cursor advances:
//   col<COLS-1 -> col+1. col=COLS-1 and row<ROWS-1 -> (row+1,0).
//   At (ROWS-1,COLS-1) -> cursor (ROWS-1,0), then go to SCR_RD (auto-scroll).
//   Otherwise -> IDLE.
//  CLEAR: one tile per cycle, raster order (0,0)..(ROWS-1,COLS-1), we=1,
//   din=FILL_CHAR. Lasts ROWS*COLS = 7200 cycles. Cursor -> (0,0), then IDLE.
//  SCR_RD/SCR_WR alternate for dst (r,c), r=0..ROWS-2, raster order:
//   SCR_RD: we=0, addr=(r+1,c). SCR_WR: we=1, addr=(r,c), din=bram_dout.
//   Total 2*(ROWS-1)*COLS = 14080 cycles, then SCR_FILL.
//  SCR_FILL: row ROWS-1, c=0..COLS-1, we=1, din=FILL_CHAR (160 cycles), then IDLE.
//   The cursor does not move on scroll_req.
//   Auto-scroll keeps the cursor at (ROWS-1,0).
//  done is asserted in the cycle after the last BRAM access; busy falls in that
//   same cycle. A request can be accepted in the cycle done is high.
// TESTING
//  Reset -> we/busy/done=0, cursor (0,0); wr_req, wr_char=8'h41 -> 1 cycle
//   we=1 addr=0 din=8'h41, cursor (0,1), done next cycle.
//  Cursor (3,159), wr_req -> write addr {6'd3,8'd159}, cursor (4,0).
//  clear_req -> exactly 7200 we cycles, addresses cover only col<160,
//   din=8'h20, busy for 7200 cycles, cursor (0,0).
//  BRAM model preloaded row r with code r, scroll_req -> row r holds r+1
//   for r<44, row 44 all 8'h20, 14240 busy cycles.
//  Cursor (44,159), wr_req 8'h5A -> 8'h5A written at (44,159), then
//   auto-scroll; char ends at (43,159), cursor (44,0).
//  clear_req+wr_req in the same cycle -> clear only. wr_req while busy -> ignored.
//   rst_sync mid-CLEAR -> we=0, busy=0 immediately.

Source files
------------

// File: rtl/tile_port_a_sequencer.sv
// Port A sequencer for the tile BRAM: cursor write, clear, scroll-up and auto-scroll.
// Write 1 cycle, clear 7200, scroll 14240; requests arriving while busy are dropped (no backpressure).
module tile_port_a_sequencer #(
  parameter int          COLS       = 160,
  parameter int          ROWS       = 45,
  parameter int          COL_BITS   = 8,
  parameter int          ROW_BITS   = 6,
  parameter int          ADDR_WIDTH = 14,
  parameter logic [7:0]  FILL_CHAR  = 8'h20
) (
  input  logic                  clk_75mhz,
  input  logic                  rst_sync,
  input  logic                  wr_req,
  input  logic [7:0]            wr_char,
  input  logic                  clear_req,
  input  logic                  scroll_req,
  input  logic [7:0]            bram_dout,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [7:0]            bram_din,
  output logic [COL_BITS-1:0]   cursor_col,
  output logic [ROW_BITS-1:0]   cursor_row,
  output logic                  busy,
  output logic                  done
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WRITE    = 3'd1;
  localparam logic [2:0] CLEAR    = 3'd2;
  localparam logic [2:0] SCR_RD   = 3'd3;
  localparam logic [2:0] SCR_WR   = 3'd4;
  localparam logic [2:0] SCR_FILL = 3'd5;

  localparam logic [COL_BITS-1:0] COL_LAST   = COL_BITS'(COLS - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST   = ROW_BITS'(ROWS - 1);
  localparam logic [ROW_BITS-1:0] ROW_PENULT = ROW_BITS'(ROWS - 2);

  logic [2:0]          state;
  logic [ROW_BITS-1:0] row_cnt;
  logic [COL_BITS-1:0] col_cnt;
  logic [7:0]          char_q;
  logic [ROW_BITS-1:0] row_src;

  assign row_src = row_cnt + ROW_BITS'(1);
  assign busy    = (state != IDLE);

  // Port A is a pure decode of state and counters so it lines up with the BRAM cycle.
  always_comb begin
    bram_we   = 1'b0;
    bram_addr = '0;
    bram_din  = 8'h00;
    case (state)
      WRITE: begin
        bram_we   = 1'b1;
        bram_addr = {cursor_row, cursor_col};
        bram_din  = char_q;
      end
      CLEAR: begin
        bram_we   = 1'b1;
        bram_addr = {row_cnt, col_cnt};
        bram_din  = FILL_CHAR;
      end
      SCR_RD: begin
        bram_addr = {row_src, col_cnt};
      end
      SCR_WR: begin
        bram_we   = 1'b1;
        bram_addr = {row_cnt, col_cnt};
        bram_din  = bram_dout;
      end
      SCR_FILL: begin
        bram_we   = 1'b1;
        bram_addr = {ROW_LAST, col_cnt};
        bram_din  = FILL_CHAR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_75mhz or posedge rst_sync) begin
    if (rst_sync) begin
      state      <= IDLE;
      row_cnt    <= '0;
      col_cnt    <= '0;
      char_q     <= 8'h00;
      cursor_col <= '0;
      cursor_row <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          row_cnt <= '0;
          col_cnt <= '0;
          if (clear_req) begin
            state <= CLEAR;
          end else if (scroll_req) begin
            state <= SCR_RD;
          end else if (wr_req) begin
            state  <= WRITE;
            char_q <= wr_char;
          end
        end
        WRITE: begin
          if (cursor_col != COL_LAST) begin
            cursor_col <= cursor_col + COL_BITS'(1);
            state      <= IDLE;
            done       <= 1'b1;
          end else if (cursor_row != ROW_LAST) begin
            cursor_col <= '0;
            cursor_row <= cursor_row + ROW_BITS'(1);
            state      <= IDLE;
            done       <= 1'b1;
          end else begin
            // Ran off the last tile: park on the start of the last row and scroll.
            cursor_col <= '0;
            state      <= SCR_RD;
          end
        end
        CLEAR: begin
          if (col_cnt == COL_LAST) begin
            col_cnt <= '0;
            if (row_cnt == ROW_LAST) begin
              state      <= IDLE;
              done       <= 1'b1;
              cursor_col <= '0;
              cursor_row <= '0;
            end else begin
              row_cnt <= row_cnt + ROW_BITS'(1);
            end
          end else begin
            col_cnt <= col_cnt + COL_BITS'(1);
          end
        end
        SCR_RD: state <= SCR_WR;
        SCR_WR: begin
          state <= SCR_RD;
          if (col_cnt == COL_LAST) begin
            col_cnt <= '0;
            if (row_cnt == ROW_PENULT) state <= SCR_FILL;
            else                       row_cnt <= row_cnt + ROW_BITS'(1);
          end else begin
            col_cnt <= col_cnt + COL_BITS'(1);
          end
        end
        SCR_FILL: begin
          if (col_cnt == COL_LAST) begin
            col_cnt <= '0;
            state   <= IDLE;
            done    <= 1'b1;
          end else begin
            col_cnt <= col_cnt + COL_BITS'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_port_a_sequencer.sv
// Directed bench for tile_port_a_sequencer with a behavioural port-A BRAM model.
module tb_tile_port_a_sequencer;

  logic        clk_75mhz = 1'b0;
  logic        rst_sync  = 1'b1;
  logic        wr_req    = 1'b0;
  logic [7:0]  wr_char   = 8'h00;
  logic        clear_req = 1'b0;
  logic        scroll_req = 1'b0;
  logic [7:0]  bram_dout;
  logic        bram_we;
  logic [13:0] bram_addr;
  logic [7:0]  bram_din;
  logic [7:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic        busy;
  logic        done;
  logic        preload = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem [0:16383];

  always #5 clk_75mhz = ~clk_75mhz;

  tile_port_a_sequencer dut (
    .clk_75mhz (clk_75mhz),
    .rst_sync  (rst_sync),
    .wr_req    (wr_req),
    .wr_char   (wr_char),
    .clear_req (clear_req),
    .scroll_req(scroll_req),
    .bram_dout (bram_dout),
    .bram_we   (bram_we),
    .bram_addr (bram_addr),
    .bram_din  (bram_din),
    .cursor_col(cursor_col),
    .cursor_row(cursor_row),
    .busy      (busy),
    .done      (done)
  );

  // Synchronous BRAM; preload fills row r with code r.
  always @(posedge clk_75mhz) begin
    if (preload) begin
      for (int r = 0; r < 45; r++)
        for (int c = 0; c < 160; c++)
          mem[r*256 + c] <= 8'(r);
    end else if (bram_we) begin
      mem[bram_addr] <= bram_din;
    end
    bram_dout <= mem[bram_addr];
  end

  task automatic do_write(input logic [7:0] ch);
    wr_req = 1'b1; wr_char = ch;
    @(negedge clk_75mhz);
    wr_req = 1'b0;
    @(negedge clk_75mhz);
  endtask

  task automatic do_preload();
    preload = 1'b1;
    @(negedge clk_75mhz);
    preload = 1'b0;
  endtask

  task automatic count_busy(output int cyc);
    cyc = 0;
    while (busy && cyc < 20000) begin
      cyc++;
      @(negedge clk_75mhz);
    end
  endtask

  task automatic test_reset();
    @(negedge clk_75mhz);
    n_cmp++; if ({bram_we, busy, done} !== 3'b000) begin n_bad++; $display("FAIL reset_ctrl got %b want 000", {bram_we, busy, done}); end
    n_cmp++; if ({cursor_row, cursor_col} !== 14'd0) begin n_bad++; $display("FAIL reset_cursor got %h want 0", {cursor_row, cursor_col}); end
    rst_sync = 1'b0;
    @(negedge clk_75mhz);
  endtask

  task automatic test_first_write();
    wr_req = 1'b1; wr_char = 8'h41;
    @(negedge clk_75mhz);
    wr_req = 1'b0;
    n_cmp++; if ({bram_we, bram_addr, bram_din} !== {1'b1, 14'd0, 8'h41}) begin n_bad++; $display("FAIL write_port got we=%b addr=%h din=%h want 1/0/41", bram_we, bram_addr, bram_din); end
    @(negedge clk_75mhz);
    n_cmp++; if ({done, busy, bram_we} !== 3'b100) begin n_bad++; $display("FAIL write_done got %b want 100", {done, busy, bram_we}); end
    n_cmp++; if ({cursor_row, cursor_col} !== {6'd0, 8'd1}) begin n_bad++; $display("FAIL write_cursor got %h want %h", {cursor_row, cursor_col}, {6'd0, 8'd1}); end
    n_cmp++; if (mem[0] !== 8'h41) begin n_bad++; $display("FAIL write_mem got %h want 41", mem[0]); end
  endtask

  task automatic test_col_wrap();
    for (int i = 0; i < 638; i++) do_write(8'h30);
    n_cmp++; if ({cursor_row, cursor_col} !== {6'd3, 8'd159}) begin n_bad++; $display("FAIL wrap_pre_cursor got %h want %h", {cursor_row, cursor_col}, {6'd3, 8'd159}); end
    wr_req = 1'b1; wr_char = 8'h42;
    @(negedge clk_75mhz);
    wr_req = 1'b0;
    n_cmp++; if ({bram_we, bram_addr} !== {1'b1, 6'd3, 8'd159}) begin n_bad++; $display("FAIL wrap_addr got %b/%h want 1/%h", bram_we, bram_addr, {6'd3, 8'd159}); end
    @(negedge clk_75mhz);
    n_cmp++; if ({cursor_row, cursor_col} !== {6'd4, 8'd0}) begin n_bad++; $display("FAIL wrap_cursor got %h want %h", {cursor_row, cursor_col}, {6'd4, 8'd0}); end
  endtask

  task automatic test_clear();
    int cyc = 0, wes = 0, bad = 0, er = 0, ec = 0;
    clear_req = 1'b1;
    @(negedge clk_75mhz);
    clear_req = 1'b0;
    while (busy && cyc < 20000) begin
      cyc++;
      if (bram_we) begin
        wes++;
        if (bram_addr[7:0] >= 8'd160 || bram_din !== 8'h20 || bram_addr !== 14'(er*256 + ec)) bad++;
        if (ec == 159) begin ec = 0; er++; end else ec++;
      end
      @(negedge clk_75mhz);
    end
    n_cmp++; if (cyc != 7200) begin n_bad++; $display("FAIL clear_busy got %0d want 7200", cyc); end
    n_cmp++; if (wes != 7200) begin n_bad++; $display("FAIL clear_we got %0d want 7200", wes); end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL clear_addr_din got %0d bad want 0", bad); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL clear_done got %b want 1", done); end
    n_cmp++; if ({cursor_row, cursor_col} !== 14'd0) begin n_bad++; $display("FAIL clear_cursor got %h want 0", {cursor_row, cursor_col}); end
  endtask

  task automatic test_scroll();
    int cyc, bad = 0;
    do_write(8'h55);
    do_preload();
    scroll_req = 1'b1;
    @(negedge clk_75mhz);
    scroll_req = 1'b0;
    count_busy(cyc);
    n_cmp++; if (cyc != 14240) begin n_bad++; $display("FAIL scroll_busy got %0d want 14240", cyc); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL scroll_done got %b want 1", done); end
    for (int r = 0; r < 45; r++)
      for (int c = 0; c < 160; c++)
        if (mem[r*256 + c] !== ((r < 44) ? 8'(r + 1) : 8'h20)) bad++;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL scroll_mem got %0d bad tiles want 0", bad); end
    n_cmp++; if ({cursor_row, cursor_col} !== {6'd0, 8'd1}) begin n_bad++; $display("FAIL scroll_cursor got %h want %h", {cursor_row, cursor_col}, {6'd0, 8'd1}); end
  endtask

  task automatic test_autoscroll();
    int cyc;
    for (int i = 0; i < 7198; i++) do_write(8'h31);
    n_cmp++; if ({cursor_row, cursor_col} !== {6'd44, 8'd159}) begin n_bad++; $display("FAIL auto_pre_cursor got %h want %h", {cursor_row, cursor_col}, {6'd44, 8'd159}); end
    do_preload();
    wr_req = 1'b1; wr_char = 8'h5A;
    @(negedge clk_75mhz);
    wr_req = 1'b0;
    n_cmp++; if ({bram_we, bram_addr, bram_din} !== {1'b1, 6'd44, 8'd159, 8'h5A}) begin n_bad++; $display("FAIL auto_write got %b/%h/%h want 1/%h/5a", bram_we, bram_addr, bram_din, {6'd44, 8'd159}); end
    count_busy(cyc);
    n_cmp++; if (cyc != 14241) begin n_bad++; $display("FAIL auto_busy got %0d want 14241", cyc); end
    n_cmp++; if (mem[43*256 + 159] !== 8'h5A) begin n_bad++; $display("FAIL auto_char got %h want 5a", mem[43*256 + 159]); end
    n_cmp++; if ({mem[43*256], mem[44*256 + 159]} !== {8'd44, 8'h20}) begin n_bad++; $display("FAIL auto_rows got %h want 2c20", {mem[43*256], mem[44*256 + 159]}); end
    n_cmp++; if ({cursor_row, cursor_col} !== {6'd44, 8'd0}) begin n_bad++; $display("FAIL auto_cursor got %h want %h", {cursor_row, cursor_col}, {6'd44, 8'd0}); end
  endtask

  task automatic test_priority();
    int cyc = 0;
    clear_req = 1'b1; wr_req = 1'b1; wr_char = 8'h77;
    @(negedge clk_75mhz);
    clear_req = 1'b0; wr_req = 1'b0;
    n_cmp++; if ({bram_addr, bram_din} !== {14'd0, 8'h20}) begin n_bad++; $display("FAIL prio_first got %h/%h want 0/20", bram_addr, bram_din); end
    while (busy && cyc < 20000) begin
      cyc++;
      wr_req = (cyc == 50);
      @(negedge clk_75mhz);
    end
    wr_req = 1'b0;
    n_cmp++; if (cyc != 7200) begin n_bad++; $display("FAIL prio_busy got %0d want 7200", cyc); end
    n_cmp++; if ({cursor_row, cursor_col} !== 14'd0) begin n_bad++; $display("FAIL prio_cursor got %h want 0", {cursor_row, cursor_col}); end
    @(negedge clk_75mhz);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_drop got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    wr_req = 1'b1; wr_char = 8'h31;
    @(negedge clk_75mhz);
    wr_req = 1'b0;
    @(negedge clk_75mhz);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_done got %b want 1", done); end
    wr_req = 1'b1; wr_char = 8'h32;
    @(negedge clk_75mhz);
    wr_req = 1'b0;
    n_cmp++; if ({bram_we, bram_addr, bram_din} !== {1'b1, 14'd1, 8'h32}) begin n_bad++; $display("FAIL b2b_write got %b/%h/%h want 1/1/32", bram_we, bram_addr, bram_din); end
    @(negedge clk_75mhz);
    n_cmp++; if ({cursor_row, cursor_col} !== {6'd0, 8'd2}) begin n_bad++; $display("FAIL b2b_cursor got %h want 2", {cursor_row, cursor_col}); end
  endtask

  task automatic test_reset_mid_clear();
    clear_req = 1'b1;
    @(negedge clk_75mhz);
    clear_req = 1'b0;
    repeat (100) @(negedge clk_75mhz);
    n_cmp++; if ({bram_we, busy} !== 2'b11) begin n_bad++; $display("FAIL mid_active got %b want 11", {bram_we, busy}); end
    rst_sync = 1'b1;
    #1;
    n_cmp++; if ({bram_we, busy, done} !== 3'b000) begin n_bad++; $display("FAIL mid_reset got %b want 000", {bram_we, busy, done}); end
    @(negedge clk_75mhz);
    rst_sync = 1'b0;
    @(negedge clk_75mhz);
    n_cmp++; if ({busy, cursor_row, cursor_col} !== 15'd0) begin n_bad++; $display("FAIL mid_after got %h want 0", {busy, cursor_row, cursor_col}); end
  endtask

  initial begin
    test_reset();
    test_first_write();
    test_col_wrap();
    test_clear();
    test_scroll();
    test_autoscroll();
    test_priority();
    test_back_to_back();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
